seq_alu: RTL

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu
// Description : Sequential ALU with valid/ready handshakes on both sides.
//               Add, sub and logic ops finish in one cycle. Shifts are done
//               one bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [SHW-1:0]   inC,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ans,
    output logic             zero,
    output logic             carry,
    output logic             ovf
);

    localparam logic [2:0] c_OP_SRA = 3'b000;
    localparam logic [2:0] c_OP_SRL = 3'b001;
    localparam logic [2:0] c_OP_SUB = 3'b010;
    localparam logic [2:0] c_OP_ADD = 3'b011;
    localparam logic [2:0] c_OP_SLL = 3'b100;
    localparam logic [2:0] c_OP_AND = 3'b101;
    localparam logic [2:0] c_OP_OR  = 3'b110;
    localparam logic [2:0] c_OP_XOR = 3'b111;
    localparam int         c_MSB    = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [SHW-1:0]   r_count;
    logic [WIDTH-1:0] r_work;
    logic [2:0]       r_op;
    logic             r_lastOut;
    logic [WIDTH-1:0] r_ans;
    logic             r_zero;
    logic             r_carry;
    logic             r_ovf;

    logic             w_isShift;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ovf;
    logic [WIDTH-1:0] w_shifted;
    logic             w_shiftOut;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign ans       = r_ans;
    assign zero      = r_zero;
    assign carry     = r_carry;
    assign ovf       = r_ovf;

    assign w_isShift = (op == c_OP_SRA) || (op == c_OP_SRL) || (op == c_OP_SLL);

    // Single-cycle result for the non-shift ops, taken straight from the inputs.
    // The extended subtraction's top bit is the unsigned borrow.
    always_comb begin
        w_sum   = {1'b0, inA} + {1'b0, inB};
        w_diff  = {1'b0, inA} - {1'b0, inB};
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (op)
            c_OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (inA[c_MSB] == inB[c_MSB]) && (w_sum[c_MSB] != inA[c_MSB]);
            end
            c_OP_SUB: begin
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
                w_ovf   = (inA[c_MSB] != inB[c_MSB]) && (w_diff[c_MSB] != inA[c_MSB]);
            end
            c_OP_AND: w_res = inA & inB;
            c_OP_OR:  w_res = inA | inB;
            c_OP_XOR: w_res = inA ^ inB;
            default:  w_res = '0;
        endcase
    end

    // One-bit step of the working register, using the op that was captured at accept.
    always_comb begin
        w_shifted  = r_work;
        w_shiftOut = 1'b0;
        case (r_op)
            c_OP_SRA: begin
                w_shifted  = {r_work[c_MSB], r_work[c_MSB:1]};
                w_shiftOut = r_work[0];
            end
            c_OP_SRL: begin
                w_shifted  = {1'b0, r_work[c_MSB:1]};
                w_shiftOut = r_work[0];
            end
            c_OP_SLL: begin
                w_shifted  = {r_work[c_MSB-1:0], 1'b0};
                w_shiftOut = r_work[c_MSB];
            end
            default: begin
                w_shifted  = r_work;
                w_shiftOut = 1'b0;
            end
        endcase
    end

    // Control FSM plus the datapath registers. The result only updates on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_work    <= '0;
            r_op      <= '0;
            r_lastOut <= 1'b0;
            r_ans     <= '0;
            r_zero    <= 1'b0;
            r_carry   <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (w_isShift) begin
                            r_state   <= S_SHIFT;
                            r_count   <= inC;
                            r_work    <= inA;
                            r_op      <= op;
                            r_lastOut <= 1'b0;
                        end else begin
                            r_state <= S_DONE;
                            r_ans   <= w_res;
                            r_zero  <= (w_res == '0);
                            r_carry <= w_carry;
                            r_ovf   <= w_ovf;
                        end
                    end
                end
                S_SHIFT: begin
                    if (r_count != '0) begin
                        r_work    <= w_shifted;
                        r_lastOut <= w_shiftOut;
                        r_count   <= r_count - SHW'(1);
                    end else begin
                        r_state <= S_DONE;
                        r_ans   <= r_work;
                        r_zero  <= (r_work == '0);
                        r_carry <= r_lastOut;
                        r_ovf   <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
